// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer
// Sole master of the PWM register block's byte bus. Loads a full PWM
// configuration atomically (disable, program, reset counter, optional
// re-enable) and takes coherent 16-bit counter snapshots from byte reads.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        config request handshake (ready only in idle)
//   cfg_period/compare1/compare2 16-bit values latched on accept
//   cfg_prescale, cfg_upnotdown, cfg_functions   latched on accept
//   cfg_done                     one-cycle pulse after the last config write
//   rd_valid_in / rd_ready       snapshot request handshake (config wins ties)
//   rd_valid_out, rd_data        one-cycle pulse with the coherent counter value
//   reg_read, reg_write, reg_addr, reg_wdata   registered bus outputs
//   reg_rdata                    read data, valid in the same cycle as reg_read
module pwm_cfg_sequencer #(
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned RST_GAP    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_compare1,
    input  logic [15:0] cfg_compare2,
    input  logic [7:0]  cfg_prescale,
    input  logic        cfg_upnotdown,
    input  logic [1:0]  cfg_functions,
    output logic        cfg_done,
    input  logic        rd_valid_in,
    output logic        rd_ready,
    output logic        rd_valid_out,
    output logic [15:0] rd_data,
    output logic        reg_read,
    output logic        reg_write,
    output logic [5:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata
);

    localparam int unsigned GapW = (RST_GAP > 1) ? $clog2(RST_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(RST_GAP - 1);

    localparam logic [5:0] AddrCntL = 6'h08;
    localparam logic [5:0] AddrCntH = 6'h09;

    typedef enum logic [2:0] {
        StIdle, StCfgWr, StCfgGap, StRdH1, StRdL, StRdH2, StRdL2, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [GapW-1:0] gap_q, gap_d;

    // Shadow copies of the request so later input changes cannot leak in.
    logic [15:0] period_q, cmp1_q, cmp2_q;
    logic [7:0]  pre_q;
    logic        ud_q;
    logic [1:0]  fn_q;

    logic [7:0]  h1_q, l_q, h2_q;

    logic        read_d, write_d;
    logic [5:0]  addr_d;
    logic [7:0]  wdata_d;
    logic        cfg_done_d, rd_valid_d;
    logic [15:0] rd_data_d;
    logic        cfg_accept;

    assign cfg_ready  = (state_q == StIdle);
    assign rd_ready   = (state_q == StIdle) && !cfg_valid;
    assign cfg_accept = cfg_valid && cfg_ready;

    // Next state plus the bus action for the next state, so the bus
    // outputs are registered yet line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        gap_d      = gap_q;
        cfg_done_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    state_d = StCfgWr;
                    step_d  = 4'd0;
                end else if (rd_valid_in) begin
                    state_d = StRdH1;
                end
            end
            StCfgWr: begin
                if (step_q == 4'd11) begin
                    state_d = StCfgGap;
                    gap_d   = '0;
                end else if (step_q == 4'd13) begin
                    state_d    = StDone;
                    cfg_done_d = 1'b1;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            StCfgGap: begin
                if (gap_q == GapLast) begin
                    if (AUTO_START) begin
                        state_d = StCfgWr;
                        step_d  = 4'd12;
                    end else begin
                        state_d    = StDone;
                        cfg_done_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StRdH1: state_d = StRdL;
            StRdL:  state_d = StRdH2;
            StRdH2: begin
                // High byte unchanged across the low read: the pair is coherent.
                if (reg_rdata == h1_q) begin
                    state_d    = StDone;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {reg_rdata, l_q};
                end else begin
                    state_d = StRdL2;
                end
            end
            StRdL2: begin
                state_d    = StDone;
                rd_valid_d = 1'b1;
                rd_data_d  = {h2_q, reg_rdata};
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = 6'h00;
        wdata_d = 8'h00;
        unique case (state_d)
            StCfgWr: begin
                write_d = 1'b1;
                case (step_d)
                    4'd0:    begin addr_d = 6'h02; wdata_d = 8'h00;            end
                    4'd1:    begin addr_d = 6'h0C; wdata_d = 8'h00;            end
                    4'd2:    begin addr_d = 6'h00; wdata_d = period_q[7:0];    end
                    4'd3:    begin addr_d = 6'h01; wdata_d = period_q[15:8];   end
                    4'd4:    begin addr_d = 6'h03; wdata_d = cmp1_q[7:0];      end
                    4'd5:    begin addr_d = 6'h04; wdata_d = cmp1_q[15:8];     end
                    4'd6:    begin addr_d = 6'h05; wdata_d = cmp2_q[7:0];      end
                    4'd7:    begin addr_d = 6'h06; wdata_d = cmp2_q[15:8];     end
                    4'd8:    begin addr_d = 6'h0A; wdata_d = pre_q;            end
                    4'd9:    begin addr_d = 6'h0B; wdata_d = {7'b0, ud_q};     end
                    4'd10:   begin addr_d = 6'h0D; wdata_d = {6'b0, fn_q};     end
                    4'd11:   begin addr_d = 6'h07; wdata_d = 8'h01;            end
                    4'd12:   begin addr_d = 6'h02; wdata_d = 8'h01;            end
                    4'd13:   begin addr_d = 6'h0C; wdata_d = 8'h01;            end
                    default: begin addr_d = 6'h00; wdata_d = 8'h00;            end
                endcase
            end
            StRdH1, StRdH2: begin
                read_d = 1'b1;
                addr_d = AddrCntH;
            end
            StRdL, StRdL2: begin
                read_d = 1'b1;
                addr_d = AddrCntL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            step_q       <= 4'd0;
            gap_q        <= '0;
            reg_read     <= 1'b0;
            reg_write    <= 1'b0;
            reg_addr     <= 6'h00;
            reg_wdata    <= 8'h00;
            cfg_done     <= 1'b0;
            rd_valid_out <= 1'b0;
            rd_data      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            reg_read     <= read_d;
            reg_write    <= write_d;
            reg_addr     <= addr_d;
            reg_wdata    <= wdata_d;
            cfg_done     <= cfg_done_d;
            rd_valid_out <= rd_valid_d;
            rd_data      <= rd_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 16'h0000;
            cmp1_q   <= 16'h0000;
            cmp2_q   <= 16'h0000;
            pre_q    <= 8'h00;
            ud_q     <= 1'b0;
            fn_q     <= 2'b00;
        end else if (cfg_accept) begin
            period_q <= cfg_period;
            cmp1_q   <= cfg_compare1;
            cmp2_q   <= cfg_compare2;
            pre_q    <= cfg_prescale;
            ud_q     <= cfg_upnotdown;
            fn_q     <= cfg_functions;
        end
    end

    // Read bytes are captured at the end of their read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= 8'h00;
            l_q  <= 8'h00;
            h2_q <= 8'h00;
        end else begin
            if (state_q == StRdH1) h1_q <= reg_rdata;
            if (state_q == StRdL)  l_q  <= reg_rdata;
            if (state_q == StRdH2) h2_q <= reg_rdata;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Testbench for pwm_cfg_sequencer: one instance with AUTO_START=1 (with a
// counter model on its read bus) and one with AUTO_START=0. Expected bus
// cycles, cfg_done and rd_valid_out events are queued with their cycle stamps
// by the stimulus; monitors pop and compare when the DUTs present them.
module tb_pwm_cfg_sequencer;

    localparam int G = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_period = '0, cfg_compare1 = '0, cfg_compare2 = '0;
    logic [7:0]  cfg_prescale = '0;
    logic        cfg_upnotdown = 1'b0;
    logic [1:0]  cfg_functions = '0;
    logic        rd_valid_in = 1'b0;
    logic [15:0] cnt = '0;

    logic        cfg_ready_a, cfg_done_a, rd_ready_a, rd_valid_out_a;
    logic [15:0] rd_data_a;
    logic        reg_read_a, reg_write_a;
    logic [5:0]  reg_addr_a;
    logic [7:0]  reg_wdata_a, reg_rdata_a;

    logic        cfg_ready_0, cfg_done_0, rd_ready_0, rd_valid_out_0;
    logic [15:0] rd_data_0;
    logic        reg_read_0, reg_write_0;
    logic [5:0]  reg_addr_0;
    logic [7:0]  reg_wdata_0;
    logic        rd_valid_0 = 1'b0;
    logic [7:0]  reg_rdata_0 = 8'h00;

    // Counter register model: combinational read data.
    assign reg_rdata_a = (reg_read_a && reg_addr_a == 6'h09) ? cnt[15:8] :
                         (reg_read_a && reg_addr_a == 6'h08) ? cnt[7:0] : 8'h00;

    pwm_cfg_sequencer #(.AUTO_START(1'b1), .RST_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
        .cfg_period(cfg_period), .cfg_compare1(cfg_compare1), .cfg_compare2(cfg_compare2),
        .cfg_prescale(cfg_prescale), .cfg_upnotdown(cfg_upnotdown),
        .cfg_functions(cfg_functions), .cfg_done(cfg_done_a),
        .rd_valid_in(rd_valid_in), .rd_ready(rd_ready_a),
        .rd_valid_out(rd_valid_out_a), .rd_data(rd_data_a),
        .reg_read(reg_read_a), .reg_write(reg_write_a), .reg_addr(reg_addr_a),
        .reg_wdata(reg_wdata_a), .reg_rdata(reg_rdata_a)
    );

    pwm_cfg_sequencer #(.AUTO_START(1'b0), .RST_GAP(G)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_0),
        .cfg_period(cfg_period), .cfg_compare1(cfg_compare1), .cfg_compare2(cfg_compare2),
        .cfg_prescale(cfg_prescale), .cfg_upnotdown(cfg_upnotdown),
        .cfg_functions(cfg_functions), .cfg_done(cfg_done_0),
        .rd_valid_in(rd_valid_0), .rd_ready(rd_ready_0),
        .rd_valid_out(rd_valid_out_0), .rd_data(rd_data_0),
        .reg_read(reg_read_0), .reg_write(reg_write_0), .reg_addr(reg_addr_0),
        .reg_wdata(reg_wdata_0), .reg_rdata(reg_rdata_0)
    );

    typedef struct {
        int         cyc;
        logic       rd;
        logic [5:0] addr;
        logic [7:0] data;
    } bus_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rdv_t;

    bus_t exp_a[$];
    bus_t exp_0[$];
    int   done_a[$];
    int   done_0[$];
    rdv_t rdv_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at cycle %0d, expected none", nm, cyc);
    endfunction

    function automatic void cmp_bus(input string nm, input bus_t e, input logic rd,
                                    input logic [5:0] a, input logic [7:0] d);
        checks++;
        if (cyc != e.cyc || rd != e.rd || a != e.addr || d != e.data) begin
            failures++;
            $display("FAIL %s: got cyc=%0d rd=%0d addr=%h data=%h, expected cyc=%0d rd=%0d addr=%h data=%h",
                     nm, cyc, rd, a, d, e.cyc, e.rd, e.addr, e.data);
        end
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (reg_read_a || reg_write_a) begin
            chk("bus_a_one_op", 32'(reg_read_a && reg_write_a), 32'd0);
            if (exp_a.size() == 0) unexpected("bus_a_op");
            else cmp_bus("bus_a", exp_a.pop_front(), reg_read_a, reg_addr_a, reg_wdata_a);
        end else begin
            chk("bus_a_idle", 32'({reg_addr_a, reg_wdata_a}), 32'd0);
        end
        if (reg_read_0 || reg_write_0) begin
            if (exp_0.size() == 0) unexpected("bus_0_op");
            else cmp_bus("bus_0", exp_0.pop_front(), reg_read_0, reg_addr_0, reg_wdata_0);
        end else begin
            chk("bus_0_idle", 32'({reg_addr_0, reg_wdata_0}), 32'd0);
        end
        if (cfg_done_a) begin
            if (done_a.size() == 0) unexpected("cfg_done_a");
            else chk("cfg_done_a_cycle", 32'(cyc), 32'(done_a.pop_front()));
        end
        if (cfg_done_0) begin
            if (done_0.size() == 0) unexpected("cfg_done_0");
            else chk("cfg_done_0_cycle", 32'(cyc), 32'(done_0.pop_front()));
        end
        if (rd_valid_out_a) begin
            if (rdv_q.size() == 0) unexpected("rd_valid_out_a");
            else begin
                rdv_t r;
                r = rdv_q.pop_front();
                chk("rd_valid_cycle", 32'(cyc), 32'(r.cyc));
                chk("rd_data", 32'(rd_data_a), 32'(r.data));
            end
        end
        if (rd_valid_out_0) unexpected("rd_valid_out_0");
    end

    // Expected config trace; n is the cycle that carries the first write.
    function automatic void push_cfg(input int n, input logic [15:0] p, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [7:0] pre,
                                     input logic ud, input logic [1:0] fn);
        logic [5:0] ad[14];
        logic [7:0] dt[14];
        ad = '{6'h02, 6'h0C, 6'h00, 6'h01, 6'h03, 6'h04, 6'h05,
               6'h06, 6'h0A, 6'h0B, 6'h0D, 6'h07, 6'h02, 6'h0C};
        dt = '{8'h00, 8'h00, p[7:0], p[15:8], c1[7:0], c1[15:8], c2[7:0],
               c2[15:8], pre, {7'b0, ud}, {6'b0, fn}, 8'h01, 8'h01, 8'h01};
        for (int k = 0; k < 12; k++) begin
            exp_a.push_back('{n + k, 1'b0, ad[k], dt[k]});
            exp_0.push_back('{n + k, 1'b0, ad[k], dt[k]});
        end
        for (int k = 12; k < 14; k++) exp_a.push_back('{n + k + G, 1'b0, ad[k], dt[k]});
        done_a.push_back(n + 14 + G);
        done_0.push_back(n + 12 + G);
    endfunction

    task automatic do_cfg(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                          input logic [7:0] pre, input logic ud, input logic [1:0] fn,
                          output int n);
        int t = 0;
        cfg_period = p; cfg_compare1 = c1; cfg_compare2 = c2;
        cfg_prescale = pre; cfg_upnotdown = ud; cfg_functions = fn;
        cfg_valid = 1'b1;
        #1;
        while (!cfg_ready_a && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!cfg_ready_a) begin
            unexpected("cfg_accept_timeout");
            cfg_valid = 1'b0;
            n = -1;
            return;
        end
        @(posedge clk); #1;
        n = cyc;
        push_cfg(n, p, c1, c2, pre, ud, fn);
        cfg_valid = 1'b0;
        // Scramble fields; shadows must keep the accepted values.
        cfg_period = 16'($urandom); cfg_compare1 = 16'($urandom); cfg_compare2 = 16'($urandom);
        cfg_prescale = 8'($urandom); cfg_upnotdown = 1'($urandom); cfg_functions = 2'($urandom);
    endtask

    task automatic do_rd(input logic [15:0] start, input bit step, input logic [15:0] expv,
                         output int n);
        int t = 0;
        cnt = start;
        rd_valid_in = 1'b1;
        #1;
        while (!rd_ready_a && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!rd_ready_a) begin
            unexpected("rd_accept_timeout");
            rd_valid_in = 1'b0;
            n = -1;
            return;
        end
        @(posedge clk); #1;
        n = cyc;
        rd_valid_in = 1'b0;
        exp_a.push_back('{n, 1'b1, 6'h09, 8'h00});
        exp_a.push_back('{n + 1, 1'b1, 6'h08, 8'h00});
        exp_a.push_back('{n + 2, 1'b1, 6'h09, 8'h00});
        if (step) begin
            exp_a.push_back('{n + 3, 1'b1, 6'h08, 8'h00});
            rdv_q.push_back('{n + 4, expv});
            // Counter advances after the low-byte read, before the second high read.
            repeat (2) @(posedge clk);
            #1 cnt = cnt + 16'd1;
        end else begin
            rdv_q.push_back('{n + 3, expv});
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_a.size() + exp_0.size() + done_a.size() + done_0.size() + rdv_q.size()) != 0
               && t < 100) begin
            @(negedge clk); t++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_read"},   32'({reg_read_a, reg_read_0}), 32'd0);
        chk({nm, "_write"},  32'({reg_write_a, reg_write_0}), 32'd0);
        chk({nm, "_addr"},   32'({reg_addr_a, reg_addr_0}), 32'd0);
        chk({nm, "_wdata"},  32'({reg_wdata_a, reg_wdata_0}), 32'd0);
        chk({nm, "_done"},   32'({cfg_done_a, cfg_done_0, rd_valid_out_a}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nc, nr;
        repeat (3) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_rd_data", 32'(rd_data_a), 32'd0);
        chk("reset_cfg_ready", 32'({cfg_ready_a, cfg_ready_0}), 32'h3);
        rst_n = 1'b1;
        @(negedge clk);

        // P=1234 C1=0400 C2=0C00: 00:34 01:12 03:00 04:04 05:00 06:0C 0A:03 0B:01 0D:02
        do_cfg(16'h1234, 16'h0400, 16'h0C00, 8'h03, 1'b1, 2'd2, n);
        drain();

        do_rd(16'h0ABC, 1'b0, 16'h0ABC, n);
        drain();

        do_rd(16'h00FF, 1'b1, 16'h0100, n);
        drain();
        repeat (3) @(negedge clk);
        chk("rd_data_hold", 32'(rd_data_a), 32'h0100);

        // Simultaneous requests: config first, snapshot right after DONE.
        @(negedge clk);
        rd_valid_in = 1'b1;
        do_cfg(16'hBEEF, 16'h1111, 16'h2222, 8'h80, 1'b0, 2'd1, nc);
        do_rd(16'h1357, 1'b0, 16'h1357, nr);
        chk("rd_accept_after_cfg", 32'(nr), 32'(nc + 16 + G));
        drain();

        // Reset in the middle of step 5 (04:C1H).
        @(negedge clk);
        do_cfg(16'h5678, 16'h9ABC, 16'hDEF0, 8'h11, 1'b1, 2'd3, n);
        repeat (6) @(negedge clk);
        #2;
        chk("step5_addr", 32'(reg_addr_a), 32'h04);
        chk("step5_data", 32'(reg_wdata_a), 32'h9A);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        exp_a.delete(); exp_0.delete(); done_a.delete(); done_0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_cfg(16'h0100, 16'h0040, 16'h0080, 8'h00, 1'b0, 2'd3, n);
        drain();

        repeat (5) @(negedge clk);
        chk("left_bus_a", 32'(exp_a.size()), 32'd0);
        chk("left_bus_0", 32'(exp_0.size()), 32'd0);
        chk("left_done_a", 32'(done_a.size()), 32'd0);
        chk("left_done_0", 32'(done_0.size()), 32'd0);
        chk("left_rdv", 32'(rdv_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
